pixel_fetch: RTL and testbench
==============================

PIXEL_FETCH -- requirements
Module: pixel_fetch

Interface
REQ-001 SHALL have parameter IMG_W, default 640, meaning pixels per line (>=2).
REQ-002 SHALL have parameter IMG_H, default 480, meaning lines per frame (>=2).
REQ-003 SHALL have parameter ADDR_W, default 19, meaning memory address width (2**ADDR_W >= IMG_W*IMG_H).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  input  1  frame request, sampled only in IDLE.
REQ-007 SHALL have ports ofs_r, ofs_g, ofs_b  input  9 each, signed  per-channel brightness offsets for the next frame.
REQ-008 SHALL have port mem_addr  output  ADDR_W  frame-memory read address, row-major (y*IMG_W+x).
REQ-009 SHALL have port mem_data  input  24  read data {R[23:16],G[15:8],B[7:0]}, valid exactly 1 cycle after address issue.
REQ-010 SHALL have port pix_ready  input  1  downstream accept.
REQ-011 SHALL have port pixel  output  24  pixel to the brightness stage.
REQ-012 SHALL have port pix_valid  output  1  pixel holds valid data.
REQ-013 SHALL have ports sof, eol, eof  output  1 each  first pixel of frame / last of line / last of frame, qualified by pix_valid.
REQ-014 SHALL have ports R, G, B  output  9 each, signed  frame-latched offsets to the brightness stage.
REQ-015 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-016 SHALL have port done  output  1  single-cycle frame-complete pulse.

Function
REQ-017 SHALL implement states IDLE, FETCH, DRAIN.
REQ-018 IDLE->FETCH SHALL occur on the edge sampling start=1; same edge latches ofs_r/g/b into R/G/B and clears x,y counters.
REQ-019 start SHALL be ignored in FETCH and DRAIN; R/G/B SHALL stay constant for the whole frame.
REQ-020 In FETCH, a read SHALL issue on any cycle where (stored + in_flight - pop) < 2; stored = FIFO entries, in_flight = 1 if a read issued last cycle, pop = pix_valid & pix_ready.
REQ-021 mem_addr SHALL equal y*IMG_W+x of the next pixel to issue; x,y SHALL advance only on issue, x wraps IMG_W-1->0 incrementing y.
REQ-022 Issuing pixel (IMG_W-1, IMG_H-1) SHALL move FETCH->DRAIN; no further reads issue.
REQ-023 Returned data SHALL be written into a 2-entry FIFO together with sof/eol/eof tag bits computed at issue time.
REQ-024 pix_valid SHALL equal FIFO non-empty; pixel/sof/eol/eof SHALL show the FIFO head; pop on pix_valid & pix_ready.
REQ-025 Simultaneous push and pop SHALL keep occupancy unchanged; FIFO SHALL never overflow or drop data under any pix_ready pattern.
REQ-026 pixel and tags SHALL stay stable while pix_valid=1 and pix_ready=0.
REQ-027 With pix_ready held 1, first pix_valid SHALL rise 2 edges after the start-sampling edge, then 1 pixel/clock with no bubbles.
REQ-028 Popping the eof pixel SHALL assert done for exactly 1 cycle and return DRAIN->IDLE on that edge.
REQ-029 busy SHALL be 1 from the start-sampling edge through the edge that pops eof.
REQ-030 Address arithmetic SHALL use ADDR_W-bit unsigned values; no combinational path from pix_ready to mem_addr beyond the REQ-020 issue enable.

Reset
REQ-031 rst=1 SHALL asynchronously force IDLE, x=y=0, FIFO empty, in_flight=0.
REQ-032 Under reset all outputs SHALL be 0: mem_addr, pixel, pix_valid, sof, eol, eof, R, G, B, busy, done.
REQ-033 Reset mid-frame SHALL abort the frame with no done pulse; data returning after reset release SHALL be discarded.
REQ-034 First start after reset release SHALL restart at address 0.

Verification (IMG_W=4, IMG_H=2, memory word = 0x0A0B00+addr)
REQ-035 start=1, ofs=(+20,-30,+5), pix_ready=1 -> pix_valid 2 edges later, pixels 0x0A0B00..0x0A0B07 back-to-back, R/G/B=20/-30/5, sof on 0, eol on 3 and 7, eof on 7, done 1 cycle.
REQ-036 pix_ready toggling 1/0 every cycle -> same 8 pixels in order, none dropped or duplicated, pixel stable while stalled.
REQ-037 pix_ready=0 for 10 cycles after start -> at most 2 reads issued, mem_addr holds 2, output holds 0x0A0B00 until release.
REQ-038 start pulsed again mid-frame with ofs=(0,0,0) -> ignored, R/G/B unchanged, one done only.
REQ-039 rst asserted after pixel 4 accepted -> all outputs 0 immediately, no done; next start emits from 0x0A0B00.
REQ-040 ofs=(-256,255,0) -> R=-256, G=255, B=0 latched exactly, signed values preserved.

Source files
------------

// File: rtl/pixel_fetch.sv
// pixel_fetch: streams one frame from a 1-cycle-latency frame memory through a 2-entry skid FIFO, with frame-latched brightness offsets.
// Ports: clk/rst (async, active-high); start + ofs_r/g/b request a frame and its offsets;
// mem_addr/mem_data form the memory read port; pixel/pix_valid/pix_ready with sof/eol/eof tags
// form the downstream stream; R/G/B are the latched offsets; busy marks a frame in progress; done pulses at frame end.
module pixel_fetch #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int ADDR_W = 19
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic signed [8:0]   ofs_r,
  input  logic signed [8:0]   ofs_g,
  input  logic signed [8:0]   ofs_b,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [23:0]         mem_data,
  input  logic                pix_ready,
  output logic [23:0]         pixel,
  output logic                pix_valid,
  output logic                sof,
  output logic                eol,
  output logic                eof,
  output logic signed [8:0]   R,
  output logic signed [8:0]   G,
  output logic signed [8:0]   B,
  output logic                busy,
  output logic                done
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] XL = XW'(IMG_W - 1);
  localparam logic [YW-1:0] YL = YW'(IMG_H - 1);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t state, state_nx;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [ADDR_W-1:0] addr;
  logic in_flight;
  logic [2:0] fl_tag;
  logic [26:0] fifo [2];
  logic rp, wp;
  logic [1:0] count;
  logic pop, issue, last, done_r;
  assign last      = x == XL && y == YL;
  assign pix_valid = count != 2'd0;
  assign pop       = pix_valid & pix_ready;
  // occupancy including the read still in the memory pipe must stay within the two FIFO slots
  assign issue     = state == FETCH && ({1'b0, count} + {2'b0, in_flight}) < (3'd2 + {2'b0, pop});
  assign {eof, eol, sof, pixel} = fifo[rp];
  assign mem_addr  = addr;
  assign busy      = state != IDLE;
  assign done      = done_r;
  always_comb begin
    state_nx = (state == IDLE && start)         ? FETCH :
               (state == FETCH && issue && last) ? DRAIN :
               (state == DRAIN && pop && eof)    ? IDLE  : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x         <= '0;
      y         <= '0;
      addr      <= '0;
      in_flight <= 1'b0;
      fl_tag    <= '0;
      fifo[0]   <= '0;
      fifo[1]   <= '0;
      rp        <= 1'b0;
      wp        <= 1'b0;
      count     <= '0;
      R         <= '0;
      G         <= '0;
      B         <= '0;
      done_r    <= 1'b0;
    end else begin
      done_r    <= pop & eof;
      in_flight <= issue;
      if (state == IDLE && start) begin
        x    <= '0;
        y    <= '0;
        addr <= '0;
        R    <= ofs_r;
        G    <= ofs_g;
        B    <= ofs_b;
      end else if (issue) begin
        // tags travel alongside the read so they line up with the returning word
        fl_tag <= {last, x == XL, x == '0 && y == '0};
        addr   <= addr + ADDR_W'(1);
        x      <= x == XL ? '0 : x + XW'(1);
        y      <= x == XL ? y + YW'(1) : y;
      end
      if (in_flight) begin
        fifo[wp] <= {fl_tag, mem_data};
        wp       <= ~wp;
      end
      if (pop) rp <= ~rp;
      count <= count + {1'b0, in_flight} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_pixel_fetch.sv
// tb_pixel_fetch: randomized self-checking bench for pixel_fetch on a 4x2 frame.
module tb_pixel_fetch;
  localparam int W = 4;
  localparam int H = 2;
  localparam int N = W * H;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic pix_ready = 1'b0;
  logic signed [8:0] ofs_r = '0, ofs_g = '0, ofs_b = '0;
  logic [2:0] mem_addr;
  logic [23:0] mem_data = '0;
  logic [23:0] pixel;
  logic pix_valid, sof, eol, eof, busy, done;
  logic signed [8:0] R, G, B;
  int total = 0;
  int bad = 0;

  pixel_fetch #(.IMG_W(W), .IMG_H(H), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst), .start(start),
    .ofs_r(ofs_r), .ofs_g(ofs_g), .ofs_b(ofs_b),
    .mem_addr(mem_addr), .mem_data(mem_data), .pix_ready(pix_ready),
    .pixel(pixel), .pix_valid(pix_valid), .sof(sof), .eol(eol), .eof(eof),
    .R(R), .G(G), .B(B), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) mem_data <= 24'h0A0B00 + 24'(mem_addr);

  // mode: 0 ready held, 1 toggling, 2 random, 3 ten-cycle stall, 4 start re-pulsed, 5 reset after pixel 4
  task automatic run_frame(input logic signed [8:0] o_r, o_g, o_b, input int mode);
    int e, idx, after;
    logic eof_pend, prev_stall, fin;
    logic [26:0] held;
    logic [23:0] xp;
    e = 0; idx = 0; after = 0;
    eof_pend = 1'b0; prev_stall = 1'b0; fin = 1'b0; held = '0;
    ofs_r = o_r; ofs_g = o_g; ofs_b = o_b;
    start = 1'b1;
    pix_ready = (mode == 0 || mode == 1 || mode == 4 || mode == 5);
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || R !== o_r || G !== o_g || B !== o_b) begin
      bad++;
      $display("FAIL latch mode=%0d got busy=%b R=%0d G=%0d B=%0d want busy=1 R=%0d G=%0d B=%0d", mode, busy, R, G, B, o_r, o_g, o_b);
    end
    while (after < 3 && e < 300) begin
      if (mode != 4) {ofs_r, ofs_g, ofs_b} = 27'($urandom);
      @(posedge clk); #1;
      e++;
      if (mode == 5 && idx == 5) begin
        rst = 1'b1;
        #1;
        total++;
        if ({mem_addr, pixel, pix_valid, sof, eol, eof, R, G, B, busy, done} !== '0) begin
          bad++;
          $display("FAIL reset_outputs got addr=%h pix=%h v=%b tags=%b%b%b R=%0d G=%0d B=%0d busy=%b done=%b want all 0",
                   mem_addr, pixel, pix_valid, sof, eol, eof, R, G, B, busy, done);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) begin
          @(posedge clk); #1;
          total++;
          if (done !== 1'b0 || pix_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_quiet got done=%b valid=%b busy=%b want 0 0 0", done, pix_valid, busy);
          end
        end
        return;
      end
      total++;
      if (R !== o_r || G !== o_g || B !== o_b) begin
        bad++;
        $display("FAIL hold_ofs e=%0d got %0d/%0d/%0d want %0d/%0d/%0d", e, R, G, B, o_r, o_g, o_b);
      end
      total++;
      if (eof_pend) begin
        if (done !== 1'b1 || busy !== 1'b0) begin
          bad++;
          $display("FAIL done_pulse e=%0d got done=%b busy=%b want done=1 busy=0", e, done, busy);
        end
        eof_pend = 1'b0;
        fin = 1'b1;
      end else if (done !== 1'b0 || busy !== !fin) begin
        bad++;
        $display("FAIL busy_done e=%0d got done=%b busy=%b want done=0 busy=%b", e, done, busy, !fin);
      end
      if (fin) after++;
      if (prev_stall) begin
        total++;
        if (pix_valid !== 1'b1 || {sof, eol, eof, pixel} !== held) begin
          bad++;
          $display("FAIL stall_hold e=%0d got v=%b %h want v=1 %h", e, pix_valid, {sof, eol, eof, pixel}, held);
        end
      end
      if (mode == 0 && !fin && idx < N) begin
        total++;
        if (pix_valid !== (e >= 2)) begin
          bad++;
          $display("FAIL stream e=%0d got valid=%b want %b", e, pix_valid, e >= 2);
        end
      end
      if (mode == 3 && e == 10) begin
        total++;
        if (mem_addr !== 3'd2 || pix_valid !== 1'b1 || pixel !== 24'h0A0B00) begin
          bad++;
          $display("FAIL stall10 got addr=%0d valid=%b pix=%h want addr=2 valid=1 pix=0a0b00", mem_addr, pix_valid, pixel);
        end
      end
      if (mode == 4 && e == 3) begin
        start = 1'b1;
        {ofs_r, ofs_g, ofs_b} = '0;
      end
      if (mode == 4 && e == 4) start = 1'b0;
      case (mode)
        1: pix_ready = ~pix_ready;
        2: pix_ready = 1'($urandom_range(0, 1));
        3: pix_ready = e > 10;
        default: pix_ready = 1'b1;
      endcase
      if (pix_valid && pix_ready) begin
        xp = 24'h0A0B00 + 24'(idx);
        total++;
        if (idx >= N || pixel !== xp || sof !== (idx == 0) || eol !== (idx % W == W - 1) || eof !== (idx == N - 1)) begin
          bad++;
          $display("FAIL pop idx=%0d got %h sof=%b eol=%b eof=%b want %h sof=%b eol=%b eof=%b",
                   idx, pixel, sof, eol, eof, xp, idx == 0, idx % W == W - 1, idx == N - 1);
        end
        if (idx == N - 1) eof_pend = 1'b1;
        idx++;
      end
      prev_stall = pix_valid && !pix_ready;
      held = {sof, eol, eof, pixel};
    end
    start = 1'b0;
    total++;
    if (idx != N || after < 3) begin
      bad++;
      $display("FAIL frame_end mode=%0d got pixels=%0d finished=%b want pixels=%0d finished=1", mode, idx, fin, N);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({mem_addr, pixel, pix_valid, sof, eol, eof, R, G, B, busy, done} !== '0) begin
      bad++;
      $display("FAIL reset_state got addr=%h pix=%h v=%b busy=%b done=%b want all 0", mem_addr, pixel, pix_valid, busy, done);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || pix_valid !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset got busy=%b valid=%b done=%b want 0 0 0", busy, pix_valid, done);
    end
  endtask

  task automatic test_basic;
    run_frame(9'sd20, -9'sd30, 9'sd5, 0);
  endtask

  task automatic test_toggle;
    run_frame(9'($urandom), 9'($urandom), 9'($urandom), 1);
  endtask

  task automatic test_stall;
    run_frame(9'($urandom), 9'($urandom), 9'($urandom), 3);
  endtask

  task automatic test_restart_ignored;
    run_frame(9'sd77, -9'sd1, 9'sd100, 4);
  endtask

  task automatic test_random;
    repeat (4) run_frame(9'($urandom), 9'($urandom), 9'($urandom), 2);
  endtask

  task automatic test_signed_ofs;
    run_frame(-9'sd256, 9'sd255, 9'sd0, 0);
  endtask

  task automatic test_mid_reset;
    run_frame(9'sd12, 9'sd34, -9'sd56, 5);
    run_frame(9'sd1, 9'sd2, 9'sd3, 0);
  endtask

  task automatic test_back_to_back;
    run_frame(9'($urandom), 9'($urandom), 9'($urandom), 0);
    run_frame(9'($urandom), 9'($urandom), 9'($urandom), 0);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_toggle;
    test_stall;
    test_restart_ignored;
    test_random;
    test_signed_ofs;
    test_mid_reset;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
